nvdla_sdp_rdma_unpack_sparse: RTL and testbench

Parametrised width down-converter for the SDP read-DMA return path. It takes one wide DMA beat (IW bits), splits it into RATIO output segments of OW bits, and sends them one per cycle over a valid/ready handshake. It adds two things a fixed splitter lacks: a runtime segment-count mode (full, half or quarter beat), and a per-segment valid mask, so empty segments are skipped rather than emitted as bubbles. It sits between the DMA read-return FIFO and the SDP datapath input.

---
 rtl/nvdla_sdp_rdma_pkg.sv | 38 +++
 rtl/nvdla_sdp_seg_sel.sv | 29 ++
 rtl/nvdla_sdp_rdma_unpack_sparse.sv | 124 ++++++++++++
 tb/tb_nvdla_sdp_rdma_unpack_sparse.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvdla_sdp_rdma_pkg.sv
// rtl/nvdla_sdp_rdma_pkg.sv - shared mode encodings and mask helpers for the SDP RDMA unpacker
package nvdla_sdp_rdma_pkg;

    localparam int MAX_RATIO = 16;

    typedef enum logic [1:0] {
        MODE_FULL    = 2'd0,
        MODE_HALF    = 2'd1,
        MODE_QUARTER = 2'd2,
        MODE_RSVD    = 2'd3
    } sdp_mode_e;

    // Reserved mode falls back to the full segment count.
    function automatic logic [MAX_RATIO-1:0] mode_mask_f(input logic [1:0] mode, input int ratio);
        int n;
        case (sdp_mode_e'(mode))
            MODE_HALF:    n = ratio / 2;
            MODE_QUARTER: n = ratio / 4;
            default:      n = ratio;
        endcase
        mode_mask_f = '0;
        for (int k = 0; k < MAX_RATIO; k++) begin
            if (k < n) begin
                mode_mask_f[k] = 1'b1;
            end
        end
    endfunction

    function automatic int ffs_f(input logic [MAX_RATIO-1:0] v);
        ffs_f = 0;
        for (int k = MAX_RATIO - 1; k >= 0; k--) begin
            if (v[k]) begin
                ffs_f = k;
            end
        end
    endfunction

endpackage

// File: rtl/nvdla_sdp_seg_sel.sv
// rtl/nvdla_sdp_seg_sel.sv - lowest-set-bit priority encoder and RATIO:1 segment mux
module nvdla_sdp_seg_sel
    import nvdla_sdp_rdma_pkg::*;
#(
    parameter int IW    = 512,
    parameter int OW    = 64,
    parameter int RATIO = 8,
    parameter int IDXW  = $clog2(RATIO)
) (
    input  logic [RATIO-1:0] rem_mask,
    input  logic [IW-1:0]    data,
    output logic [IDXW-1:0]  cur_idx,
    output logic [OW-1:0]    seg_data,
    output logic             one_hot
);

    assign cur_idx = IDXW'(ffs_f(MAX_RATIO'(rem_mask)));
    assign one_hot = (rem_mask != '0) && ((rem_mask & (rem_mask - RATIO'(1))) == '0);

    always_comb begin
        seg_data = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (cur_idx == IDXW'(k)) begin
                seg_data = data[k*OW +: OW];
            end
        end
    end

endmodule

// File: rtl/nvdla_sdp_rdma_unpack_sparse.sv
// rtl/nvdla_sdp_rdma_unpack_sparse.sv - wide DMA beat to masked OW-bit segment down-converter
module nvdla_sdp_rdma_unpack_sparse
    import nvdla_sdp_rdma_pkg::*;
#(
    parameter int IW    = 512,
    parameter int OW    = 64,
    parameter int RATIO = 8,
    parameter int CW    = 1,
    parameter int DCW   = 16
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic [1:0]       cfg_mode,
    input  logic             inp_pvld,
    output logic             inp_prdy,
    input  logic [IW-1:0]    inp_data,
    input  logic [RATIO-1:0] inp_mask,
    input  logic [CW-1:0]    inp_ctrl,
    output logic             out_pvld,
    input  logic             out_prdy,
    output logic [OW-1:0]    out_data,
    output logic [CW-1:0]    out_ctrl,
    output logic             out_first,
    output logic             out_last,
    output logic [DCW-1:0]   drop_cnt
);

    localparam int IDXW = $clog2(RATIO);

    logic             hold_vld_q, hold_vld_d;
    logic [RATIO-1:0] rem_mask_q, rem_mask_d;
    logic             first_pend_q, first_pend_d;
    logic [DCW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [IW-1:0]    hold_data_q;
    logic [CW-1:0]    hold_ctrl_q;

    logic [RATIO-1:0] eff;
    logic [RATIO-1:0] cur_oh;
    logic [IDXW-1:0]  cur_idx;
    logic             one_hot;
    logic             inp_acc;
    logic             out_acc;

    nvdla_sdp_seg_sel #(
        .IW    (IW),
        .OW    (OW),
        .RATIO (RATIO),
        .IDXW  (IDXW)
    ) u_seg_sel (
        .rem_mask (rem_mask_q),
        .data     (hold_data_q),
        .cur_idx  (cur_idx),
        .seg_data (out_data),
        .one_hot  (one_hot)
    );

    // Mode only matters at acceptance; the held beat carries its own resolved mask.
    assign eff = inp_mask & RATIO'(mode_mask_f(cfg_mode, RATIO));

    assign out_pvld  = hold_vld_q;
    assign out_last  = hold_vld_q & one_hot;
    assign out_first = hold_vld_q & first_pend_q;
    assign out_ctrl  = out_last ? hold_ctrl_q : '0;
    assign drop_cnt  = drop_cnt_q;

    assign inp_prdy = !hold_vld_q | (out_prdy & out_last);
    assign inp_acc  = inp_pvld & inp_prdy;
    assign out_acc  = out_pvld & out_prdy;

    always_comb begin
        cur_oh = '0;
        for (int k = 0; k < RATIO; k++) begin
            cur_oh[k] = (cur_idx == IDXW'(k));
        end
    end

    always_comb begin
        hold_vld_d   = hold_vld_q;
        rem_mask_d   = rem_mask_q;
        first_pend_d = first_pend_q;
        drop_cnt_d   = drop_cnt_q;
        if (out_acc) begin
            first_pend_d = 1'b0;
            if (out_last) begin
                hold_vld_d = 1'b0;
                rem_mask_d = '0;
            end else begin
                rem_mask_d = rem_mask_q & ~cur_oh;
            end
        end
        // A same-cycle load overrides the last-segment retire, so single-segment beats stream without bubbles.
        if (inp_acc) begin
            if (eff != '0) begin
                hold_vld_d   = 1'b1;
                rem_mask_d   = eff;
                first_pend_d = 1'b1;
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DCW'(1);
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            hold_vld_q   <= 1'b0;
            rem_mask_q   <= '0;
            first_pend_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            hold_vld_q   <= hold_vld_d;
            rem_mask_q   <= rem_mask_d;
            first_pend_q <= first_pend_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (inp_acc && (eff != '0)) begin
            hold_data_q <= inp_data;
            hold_ctrl_q <= inp_ctrl;
        end
    end

endmodule

// File: tb/tb_nvdla_sdp_rdma_unpack_sparse.sv
// tb/tb_nvdla_sdp_rdma_unpack_sparse.sv - scoreboard bench for the SDP RDMA sparse unpacker
module tb_nvdla_sdp_rdma_unpack_sparse;

    localparam int IW    = 512;
    localparam int OW    = 64;
    localparam int RATIO = 8;
    localparam int CW    = 1;
    localparam int DCW   = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic [1:0]       cfg_mode;
    logic             inp_pvld;
    logic             inp_prdy;
    logic [IW-1:0]    inp_data;
    logic [RATIO-1:0] inp_mask;
    logic [CW-1:0]    inp_ctrl;
    logic             out_pvld;
    logic             out_prdy;
    logic [OW-1:0]    out_data;
    logic [CW-1:0]    out_ctrl;
    logic             out_first;
    logic             out_last;
    logic [DCW-1:0]   drop_cnt;

    typedef struct packed {
        logic [63:0] data;
        logic        first;
        logic        last;
        logic        ctrl;
    } seg_t;

    seg_t sb_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   exp_drop = 0;

    nvdla_sdp_rdma_unpack_sparse #(
        .IW(IW), .OW(OW), .RATIO(RATIO), .CW(CW), .DCW(DCW)
    ) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .cfg_mode        (cfg_mode),
        .inp_pvld        (inp_pvld),
        .inp_prdy        (inp_prdy),
        .inp_data        (inp_data),
        .inp_mask        (inp_mask),
        .inp_ctrl        (inp_ctrl),
        .out_pvld        (out_pvld),
        .out_prdy        (out_prdy),
        .out_data        (out_data),
        .out_ctrl        (out_ctrl),
        .out_first       (out_first),
        .out_last        (out_last),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] rand_beat();
        logic [IW-1:0] d;
        for (int k = 0; k < IW / 32; k++) begin
            d[32*k +: 32] = $urandom;
        end
        return d;
    endfunction

    task automatic send_beat(input logic [1:0] mode, input logic [7:0] mask,
                             input logic [IW-1:0] data, input logic ctrl, output int waits);
        logic [7:0] mm;
        logic [7:0] eff;
        int         n;
        int         seen;
        cfg_mode = mode;
        inp_mask = mask;
        inp_data = data;
        inp_ctrl = ctrl;
        inp_pvld = 1'b1;
        waits    = 0;
        @(negedge clk);
        while (!inp_prdy && waits < 50) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            waits++;
        end
        if (!inp_prdy) begin
            chk("send_timeout", 64'd0, 64'd1);
            inp_pvld = 1'b0;
            return;
        end
        case (mode)
            2'd1:    mm = 8'h0F;
            2'd2:    mm = 8'h03;
            default: mm = 8'hFF;
        endcase
        eff  = mask & mm;
        n    = $countones(eff);
        seen = 0;
        if (n == 0) begin
            if (exp_drop < 65535) exp_drop++;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (eff[k]) begin
                    seen++;
                    sb_q.push_back('{data[64*k +: 64], seen == 1, seen == n, (seen == n) ? ctrl : 1'b0});
                end
            end
        end
        @(posedge clk);
        #1;
        inp_pvld = 1'b0;
    endtask

    task automatic drain(output int cycles);
        cycles = 0;
        while (sb_q.size() != 0 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("drain_done", 64'(sb_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        seg_t e;
        if (rstn && out_pvld && out_prdy) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_seg", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("seg_data", out_data, e.data);
                chk("seg_first", 64'(out_first), 64'(e.first));
                chk("seg_last", 64'(out_last), 64'(e.last));
                chk("seg_ctrl", 64'(out_ctrl), 64'(e.ctrl));
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] d;
        int            w;
        int            cyc;

        rstn     = 1'b0;
        cfg_mode = 2'd0;
        inp_pvld = 1'b0;
        inp_data = '0;
        inp_mask = '0;
        inp_ctrl = '0;
        out_prdy = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_pvld", 64'(out_pvld), 64'd0);
        chk("rst_out_first", 64'(out_first), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_inp_prdy", 64'(inp_prdy), 64'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // full beat
        d = rand_beat();
        send_beat(2'd0, 8'hFF, d, 1'b1, w);
        chk("full_latency", 64'(out_pvld), 64'd1);
        drain(cyc);
        chk("full_cycles", 64'(cyc), 64'd8);

        // half mode ignores upper mask bits
        d = rand_beat();
        send_beat(2'd1, 8'hFF, d, 1'b1, w);
        drain(cyc);
        chk("half_cycles", 64'(cyc), 64'd4);

        // sparse mask, no bubbles
        d = rand_beat();
        send_beat(2'd0, 8'hA5, d, 1'b1, w);
        chk("sparse_latency", 64'(out_pvld), 64'd1);
        drain(cyc);
        chk("sparse_cycles", 64'(cyc), 64'd4);

        // reserved mode behaves as full
        d = rand_beat();
        send_beat(2'd3, 8'h81, d, 1'b1, w);
        drain(cyc);
        chk("rsvd_cycles", 64'(cyc), 64'd2);

        // empty beats are dropped and counted
        send_beat(2'd0, 8'h00, rand_beat(), 1'b1, w);
        chk("drop_prdy", 64'(w), 64'd0);
        chk("drop_no_out", 64'(out_pvld), 64'd0);
        chk("drop_cnt_1", 64'(drop_cnt), 64'd1);
        send_beat(2'd2, 8'hF0, rand_beat(), 1'b0, w);
        chk("drop_q_no_out", 64'(out_pvld), 64'd0);
        chk("drop_cnt_2", 64'(drop_cnt), 64'(exp_drop));

        // back-to-back single-segment beats
        for (int i = 0; i < 4; i++) begin
            send_beat(2'd0, 8'h01, rand_beat(), 1'(i), w);
            chk("b2b_no_wait", 64'(w), 64'd0);
        end
        drain(cyc);
        chk("b2b_drain", 64'(cyc), 64'd1);

        // mixed back-to-back, multi segment followed by single
        send_beat(2'd0, 8'h18, rand_beat(), 1'b1, w);
        send_beat(2'd0, 8'h40, rand_beat(), 1'b0, w);
        chk("mixed_wait", 64'(w), 64'd1);
        drain(cyc);

        // backpressure after seg2, then reset mid-beat
        d = rand_beat();
        send_beat(2'd0, 8'hFF, d, 1'b1, w);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        out_prdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_data", out_data, d[128 +: 64]);
            chk("bp_pvld", 64'(out_pvld), 64'd1);
            chk("bp_first", 64'(out_first), 64'd0);
            chk("bp_last", 64'(out_last), 64'd0);
            chk("bp_inp_prdy", 64'(inp_prdy), 64'd0);
        end
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_pvld", 64'(out_pvld), 64'd0);
        sb_q.delete();
        exp_drop = 0;
        out_prdy = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 64'(out_pvld), 64'd0);
        chk("post_rst_drop", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1;
        d = rand_beat();
        send_beat(2'd0, 8'hFF, d, 1'b0, w);
        chk("post_rst_first", 64'(out_first), 64'd1);
        chk("post_rst_seg0", out_data, d[63:0]);
        drain(cyc);
        chk("post_rst_cycles", 64'(cyc), 64'd8);

        // drop counter saturation
        for (int i = 0; i < 65535; i++) begin
            send_beat(2'd0, 8'h00, '0, 1'b0, w);
        end
        chk("drop_sat_reach", 64'(drop_cnt), 64'hFFFF);
        send_beat(2'd0, 8'h00, '0, 1'b0, w);
        chk("drop_sat_hold", 64'(drop_cnt), 64'hFFFF);
        chk("drop_sat_model", 64'(drop_cnt), 64'(exp_drop));

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
